// File: rtl/scmp_microcode_seq.sv
// SC/MP microcode sequencer: micro-PC stepping, decoder dispatch, bus-wait and hold stalls.
// Optional bus watchdog enabled by defining SCMP_USEQ_WDOG_EN.
module scmp_microcode_seq #(
    parameter int                UPC_W       = 6,
    parameter logic [UPC_W-1:0]  RESET_UPC   = '0,
    parameter logic [UPC_W-1:0]  ABORT_UPC   = '0,
    parameter int                WDOG_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [UPC_W-1:0] i_op_pc,
    input  logic [1:0]       i_mc_next,
    input  logic [UPC_W-1:0] i_mc_addr,
    input  logic             i_mc_bus,
    input  logic             i_bus_ack,
    input  logic             i_cond,
    input  logic             i_hold,
    output logic [UPC_W-1:0] o_upc,
    output logic             o_stall,
    output logic             o_dispatch,
    output logic             o_bus_timeout
);

    typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_WAIT, ST_HOLD} state_e;

    localparam logic [1:0] MC_INC  = 2'b00;
    localparam logic [1:0] MC_JMP  = 2'b01;
    localparam logic [1:0] MC_DEC  = 2'b10;
    localparam logic [1:0] MC_COND = 2'b11;

    state_e           state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic             dispatch_q, dispatch_d;
    logic [UPC_W-1:0] nxt_upc;
    logic [UPC_W-1:0] upc_inc;
    logic             is_decode;

`ifdef SCMP_USEQ_WDOG_EN
    localparam int              CNT_W    = $clog2(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ABORT_UPC, WDOG_CYCLES};
`endif

    // Successor address of the microword currently addressed by o_upc
    always_comb begin
        upc_inc   = upc_q + 1'b1;
        is_decode = (i_mc_next == MC_DEC);
        nxt_upc   = upc_inc;
        case (i_mc_next)
            MC_INC:  nxt_upc = upc_inc;
            MC_JMP:  nxt_upc = i_mc_addr;
            MC_DEC:  nxt_upc = i_op_pc;
            MC_COND: nxt_upc = i_cond ? i_mc_addr : upc_inc;
            default: nxt_upc = upc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            upc_q      <= RESET_UPC;
            dispatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            upc_q      <= upc_d;
            dispatch_q <= dispatch_d;
        end
    end

`ifdef SCMP_USEQ_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        dispatch_d = 1'b0;
`ifdef SCMP_USEQ_WDOG_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN: begin
                // Hold is tested first: decode microwords never carry a bus cycle
                if (is_decode && i_hold) begin
                    state_d = ST_HOLD;
                end else if (i_mc_bus && !i_bus_ack) begin
                    state_d = ST_WAIT;
`ifdef SCMP_USEQ_WDOG_EN
                    cnt_d   = '0;
`endif
                end else begin
                    upc_d      = nxt_upc;
                    dispatch_d = is_decode;
                end
            end
            ST_WAIT: begin
                if (i_bus_ack) begin
                    upc_d      = nxt_upc;
                    dispatch_d = is_decode;
                    state_d    = ST_RUN;
                end
`ifdef SCMP_USEQ_WDOG_EN
                else if (cnt_q == CNT_LAST) begin
                    upc_d     = ABORT_UPC;
                    timeout_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (!i_hold) begin
                    upc_d      = i_op_pc;
                    dispatch_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        o_stall    = (state_q != ST_RUN) | (i_mc_bus & ~i_bus_ack);
        o_upc      = upc_q;
        o_dispatch = dispatch_q;
`ifdef SCMP_USEQ_WDOG_EN
        o_bus_timeout = timeout_q;
`else
        o_bus_timeout = 1'b0;
`endif
    end

endmodule

// File: tb/tb_scmp_microcode_seq.sv
// Bench for scmp_microcode_seq: directed scenarios plus randomized microword streams,
// checked through an expectation queue against a behavioural sequencer model.
module tb_scmp_microcode_seq;

    localparam int              UPC_W = 6;
    localparam int              WDOG  = 16;
    localparam logic [UPC_W-1:0] ABORT = 6'h15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [UPC_W-1:0] i_op_pc = '0;
    logic [1:0]       i_mc_next = 2'b00;
    logic [UPC_W-1:0] i_mc_addr = '0;
    logic             i_mc_bus = 1'b0;
    logic             i_bus_ack = 1'b0;
    logic             i_cond = 1'b0;
    logic             i_hold = 1'b0;
    logic [UPC_W-1:0] o_upc;
    logic             o_stall;
    logic             o_dispatch;
    logic             o_bus_timeout;

    scmp_microcode_seq #(
        .UPC_W(UPC_W), .RESET_UPC(6'h00), .ABORT_UPC(ABORT), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_op_pc(i_op_pc), .i_mc_next(i_mc_next),
        .i_mc_addr(i_mc_addr), .i_mc_bus(i_mc_bus), .i_bus_ack(i_bus_ack),
        .i_cond(i_cond), .i_hold(i_hold), .o_upc(o_upc), .o_stall(o_stall),
        .o_dispatch(o_dispatch), .o_bus_timeout(o_bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             stall;
        logic [UPC_W-1:0] upc;
        logic             disp;
        logic             tmo;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: where the sequencer is and what it shows
    logic             m_rst = 1'b1;
    logic             m_wait = 1'b0;
    logic             m_hold = 1'b0;
    logic [UPC_W-1:0] m_upc = '0;
    logic             m_disp = 1'b0;
    logic             m_tmo = 1'b0;
`ifdef SCMP_USEQ_WDOG_EN
    int               m_cnt = 0;
`endif

    logic             s_r;
    logic [1:0]       s_nx = 2'b00;
    logic [UPC_W-1:0] s_ad = '0;
    logic             s_bs = 1'b0;
    logic             s_ak, s_cd, s_hd;
    logic [UPC_W-1:0] s_op;

    task automatic cyc(input logic r, input logic [1:0] nx, input logic [UPC_W-1:0] ad,
                       input logic bs, input logic ak, input logic cd, input logic hd,
                       input logic [UPC_W-1:0] op);
        exp_t             e;
        logic [UPC_W-1:0] tgt;
        logic             dec;
        @(negedge clk);
        rst_n = r; i_mc_next = nx; i_mc_addr = ad; i_mc_bus = bs;
        i_bus_ack = ak; i_cond = cd; i_hold = hd; i_op_pc = op;
        if (!r) begin
            m_rst = 1'b1; m_wait = 1'b0; m_hold = 1'b0;
            m_upc = '0; m_disp = 1'b0; m_tmo = 1'b0;
        end
        e.stall = m_rst | m_wait | m_hold | (bs & !ak);
        e.upc   = m_upc;
        e.disp  = m_disp;
        e.tmo   = m_tmo;
        exp_q.push_back(e);
        if (r) begin
            tgt = UPC_W'((int'(m_upc) + 1) % (1 << UPC_W));
            if (nx == 2'd1 || (nx == 2'd3 && cd)) tgt = ad;
            if (nx == 2'd2) tgt = op;
            dec = (nx == 2'd2);
            m_disp = 1'b0;
            m_tmo  = 1'b0;
            if (m_rst) begin
                m_rst = 1'b0;
            end else if (m_hold) begin
                if (!hd) begin m_hold = 1'b0; m_upc = op; m_disp = 1'b1; end
            end else if (m_wait) begin
                if (ak) begin m_wait = 1'b0; m_upc = tgt; m_disp = dec; end
`ifdef SCMP_USEQ_WDOG_EN
                else if (m_cnt == WDOG - 1) begin m_wait = 1'b0; m_upc = ABORT; m_tmo = 1'b1; end
                else m_cnt = m_cnt + 1;
`endif
            end else begin
                if (dec && hd) m_hold = 1'b1;
                else if (bs && !ak) begin
                    m_wait = 1'b1;
`ifdef SCMP_USEQ_WDOG_EN
                    m_cnt = 0;
`endif
                end else begin m_upc = tgt; m_disp = dec; end
            end
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (o_stall !== e.stall) begin
                    miscompares++;
                    $display("FAIL stall t=%0t got %b want %b", $time, o_stall, e.stall);
                end
                if (o_upc !== e.upc) begin
                    miscompares++;
                    $display("FAIL upc t=%0t got %h want %h", $time, o_upc, e.upc);
                end
                if (o_dispatch !== e.disp) begin
                    miscompares++;
                    $display("FAIL dispatch t=%0t got %b want %b", $time, o_dispatch, e.disp);
                end
                if (o_bus_timeout !== e.tmo) begin
                    miscompares++;
                    $display("FAIL bus_timeout t=%0t got %b want %b", $time, o_bus_timeout, e.tmo);
                end
            end
        end
    end

    initial begin
        // Reset, release, wrap, jump, conditional branch
        cyc(0, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
        cyc(0, 2'd0, 6'h00, 0, 1, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd1, 6'h3F, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd1, 6'h2A, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd1, 6'h05, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd3, 6'h20, 0, 0, 1, 0, 6'h00);
        cyc(1, 2'd1, 6'h05, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd3, 6'h20, 0, 0, 0, 0, 6'h00);
        // Bus cycle with two wait states, then zero-wait and ack-without-bus
        cyc(1, 2'd1, 6'h03, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 1, 1, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 1, 1, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 1, 0, 0, 6'h00);
        // Decode with hold for two cycles, then dispatch to 0x12; plain decode dispatch
        cyc(1, 2'd2, 6'h00, 0, 0, 0, 1, 6'h12);
        cyc(1, 2'd2, 6'h00, 0, 1, 0, 1, 6'h12);
        cyc(1, 2'd2, 6'h00, 0, 0, 0, 0, 6'h12);
        cyc(1, 2'd2, 6'h00, 0, 0, 0, 0, 6'h31);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
        // Reset in the middle of a bus wait
        cyc(1, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(0, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
`ifdef SCMP_USEQ_WDOG_EN
        // Watchdog expiry, then ack arriving on the last permitted wait cycle
        cyc(1, 2'd1, 6'h07, 0, 0, 0, 0, 6'h00);
        for (int i = 0; i < WDOG + 1; i++) cyc(1, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(1, 2'd1, 6'h07, 0, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
        for (int i = 0; i < WDOG; i++) cyc(1, 2'd0, 6'h00, 1, 0, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 1, 1, 0, 0, 6'h00);
        cyc(1, 2'd0, 6'h00, 0, 0, 0, 0, 6'h00);
`endif
        // Random microword streams; the microword is held while the model is stalled
        for (int i = 0; i < 1500; i++) begin
            if (!m_wait && !m_hold) begin
                s_nx = 2'($urandom_range(3));
                s_ad = UPC_W'($urandom);
                s_bs = (s_nx != 2'd2) && ($urandom_range(2) == 0);
            end
            s_ak = ($urandom_range(2) == 0);
            s_cd = 1'($urandom);
            s_hd = ($urandom_range(3) == 0);
            s_op = UPC_W'($urandom);
            s_r  = ($urandom_range(199) != 0);
            cyc(s_r, s_nx, s_ad, s_bs, s_ak, s_cd, s_hd, s_op);
        end
        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
